// File: rtl/mem_req_arbiter.sv
// N-channel memory request arbiter, round-robin or fixed priority (ARB_FIXED_PRIO_EN); one grant at a time.
// Latency: request sampled in IDLE -> mem_* next cycle; ch_resp same cycle as mem_resp, then one IDLE cycle.
// Backpressure: requesters hold read/write until their ch_resp; inputs are ignored while a grant is outstanding.
module mem_req_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [BE_W-1:0]          mem_byte_enable,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_resp,
  output logic                     busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] req;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  int                cand;
  logic              start_grant;
  logic              complete;

  assign req         = ch_read | ch_write;
  assign ch_rdata    = mem_rdata;
  assign busy        = (state_q == BUSY);
  assign start_grant = (state_q == IDLE) && win_found;
  assign complete    = (state_q == BUSY) && mem_resp;

  // Ascending search from rr_ptr with wrap; in fixed-priority builds rr_ptr is 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ch_resp = '0;
    case (state_q)
      IDLE: if (win_found) state_d = BUSY;
      BUSY: begin
        if (mem_resp) begin
          ch_resp[grant_q] = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Winner fields are captured once; the mem_* outputs hold them for the whole grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q         <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else if (start_grant) begin
      grant_q         <= win_idx;
      mem_write       <= ch_write[win_idx];
      mem_read        <= ch_read[win_idx] & ~ch_write[win_idx];
      mem_address     <= ch_address[int'(win_idx)*ADDR_W +: ADDR_W];
      mem_wdata       <= ch_wdata[int'(win_idx)*DATA_W +: DATA_W];
      mem_byte_enable <= ch_byte_enable[int'(win_idx)*BE_W +: BE_W];
    end else if (complete) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_ptr <= '0;
    else if (complete) rr_ptr <= (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NUM_CH=4) with a scoreboard of expected downstream transactions.
module tb_mem_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    ch_read;
  logic [N-1:0]    ch_write;
  logic [N*AW-1:0] ch_address;
  logic [N*DW-1:0] ch_wdata;
  logic [N*BW-1:0] ch_byte_enable;
  logic [DW-1:0]   ch_rdata;
  logic [N-1:0]    ch_resp;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_byte_enable;
  logic [DW-1:0]   mem_rdata;
  logic            mem_resp;
  logic            busy;

  mem_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ch_read(ch_read), .ch_write(ch_write), .ch_address(ch_address),
    .ch_wdata(ch_wdata), .ch_byte_enable(ch_byte_enable),
    .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            ch;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    ch_address[i*AW +: AW]     = a;
    ch_wdata[i*DW +: DW]       = d;
    ch_byte_enable[i*BW +: BW] = b;
  endtask

  task automatic push_exp(input int i, input logic rd, input logic wr);
    exp_t e;
    e.ch    = i;
    e.rd    = rd;
    e.wr    = wr;
    e.addr  = ch_address[i*AW +: AW];
    e.wdata = ch_wdata[i*DW +: DW];
    e.be    = ch_byte_enable[i*BW +: BW];
    sb.push_back(e);
  endtask

  // Downstream model: waits for a grant, checks it against the next expected
  // transaction, responds after lat busy cycles, then checks the idle cycle.
  task automatic serve(input int exp_wait, input int lat, input logic [DW-1:0] rdata, input logic [N-1:0] drop);
    exp_t          e;
    int            n;
    logic [N-1:0]  onehot;
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
        tick();
        n++;
      end
      if (exp_wait >= 0) chk("grant_wait", 64'(n), 64'(exp_wait));
      chk("mem_read", 64'(mem_read), 64'(e.rd));
      chk("mem_write", 64'(mem_write), 64'(e.wr));
      chk("mem_address", 64'(mem_address), 64'(e.addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
      chk("mem_be", 64'(mem_byte_enable), 64'(e.be));
      chk("busy_hi", 64'(busy), 64'd1);
      for (int k = 1; k < lat; k++) begin
        tick();
        chk("hold_wdata", 64'(mem_wdata), 64'(e.wdata));
        chk("hold_addr", 64'(mem_address), 64'(e.addr));
        chk("hold_resp0", 64'(ch_resp), 64'd0);
      end
      mem_rdata = rdata;
      mem_resp  = 1'b1;
      #1;
      onehot = N'(1) << e.ch;
      chk("ch_resp", 64'(ch_resp), 64'(onehot));
      chk("ch_rdata", 64'(ch_rdata), 64'(rdata));
      tick();
      mem_resp = 1'b0;
      ch_read  = ch_read & ~drop;
      ch_write = ch_write & ~drop;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_mem_op", 64'({mem_read, mem_write}), 64'd0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    ch_read        = '0;
    ch_write       = '0;
    ch_address     = '0;
    ch_wdata       = '0;
    ch_byte_enable = '0;
    mem_rdata      = 32'hA5A5_5A5A;
    mem_resp       = 1'b0;
    #2;
    chk("rst_mem_op", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_be", 64'(mem_byte_enable), 64'd0);
    chk("rst_resp", 64'(ch_resp), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rdata_pass", 64'(ch_rdata), 64'h A5A5_5A5A);
    tick();
    rst = 1'b0;

    // Single read on channel 1
    set_ch(1, 32'h0000_0100, 32'h0, 4'h0);
    ch_read = 4'b0010;
    push_exp(1, 1'b1, 1'b0);
    serve(1, 3, 32'hDEAD_BEEF, 4'b0010);

    // mem_resp while idle is ignored
    mem_resp = 1'b1;
    #1;
    chk("idle_resp_none", 64'(ch_resp), 64'd0);
    tick();
    mem_resp = 1'b0;
    chk("idle_resp_busy", 64'(busy), 64'd0);

    // Write on channel 2; wdata change mid-grant must not reach mem_wdata
    set_ch(2, 32'h8000_0004, 32'h1234_5678, 4'b0011);
    ch_write = 4'b0100;
    push_exp(2, 1'b0, 1'b1);
    tick();
    ch_wdata[2*DW +: DW] = 32'hFFFF_0000;
    serve(0, 3, 32'h0, 4'b0100);
    set_ch(2, 32'h0, 32'h0, 4'h0);

    // Read and write together: write wins
    set_ch(0, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111);
    ch_read  = 4'b0001;
    ch_write = 4'b0001;
    push_exp(0, 1'b0, 1'b1);
    serve(1, 2, 32'h0, 4'b0001);

    // Asynchronous reset in the middle of a grant
    for (int i = 0; i < N; i++) set_ch(i, 32'h1000 + 32'(i) * 32'h10, 32'(i) + 32'h50, 4'hF);
    ch_read = '1;
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mem_op", 64'({mem_read, mem_write}), 64'd0);
    chk("arst_addr", 64'(mem_address), 64'd0);
    chk("arst_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_be", 64'(mem_byte_enable), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("post_rst_busy0", 64'(busy), 64'd0);
    tick();
    chk("post_rst_busy1", 64'(busy), 64'd1);

    // Contention: all four channels continuously requesting, order 0,1,2,3,0,1
    push_exp(0, 1'b1, 1'b0);
    push_exp(1, 1'b1, 1'b0);
    push_exp(2, 1'b1, 1'b0);
    push_exp(3, 1'b1, 1'b0);
    push_exp(0, 1'b1, 1'b0);
    push_exp(1, 1'b1, 1'b0);
    serve(0, 2, 32'h1111_0000, 4'b0000);
    for (int r = 0; r < 4; r++) serve(1, 2, 32'h1111_0001 + 32'(r), 4'b0000);
    serve(1, 2, 32'h1111_0009, 4'b1111);

    // Channels 0 and 2 continuously requesting after a fresh reset
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    ch_read = 4'b0101;
`ifdef ARB_FIXED_PRIO_EN
    for (int r = 0; r < 4; r++) push_exp(0, 1'b1, 1'b0);
`else
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 1'b1, 1'b0);
      push_exp(2, 1'b1, 1'b0);
    end
`endif
    for (int r = 0; r < 3; r++) serve(1, 1, 32'h2222_0000 + 32'(r), 4'b0000);
    serve(1, 1, 32'h2222_0003, 4'b1111);
    tick();
    chk("final_idle", 64'(busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-channel memory request arbiter that merges independent cache-side request ports onto one shared downstream memory port. It generalises the fixed split icache/dcache hookup of the CPU top to any number of requesters, for example icache, dcache and prefetcher sharing one unified L2 or memory port. Each requester uses the codebase read/write/resp handshake. The arbiter grants one channel at a time, latches the winning request and routes the response back.

## Interface
Parameters:
- NUM_CH, 2, number of request channels (≥2; need not be a power of two)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); byte-enable width BE_W = DATA_W/8

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- ch_read  input  NUM_CH  per-channel read request
- ch_write  input  NUM_CH  per-channel write request
- ch_address  input  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  input  NUM_CH*DATA_W  packed write data
- ch_byte_enable  input  NUM_CH*BE_W  packed byte enables
- ch_rdata  output  DATA_W  read data, broadcast to all channels
- ch_resp  output  NUM_CH  one-hot response to the granted channel
- mem_read  output  1  downstream read request
- mem_write  output  1  downstream write request
- mem_address  output  ADDR_W  downstream address
- mem_wdata  output  DATA_W  downstream write data
- mem_byte_enable  output  BE_W  downstream byte enables
- mem_rdata  input  DATA_W  downstream read data
- mem_resp  input  1  downstream completion
- busy  output  1  high while a grant is outstanding

## Operation
- FSM with two states: IDLE and BUSY. Reset state is IDLE.
- IDLE:
  - A channel requests when ch_read[i] | ch_write[i].
  - If any channel requests, pick a winner:
    - Round-robin search starting at rr_ptr, ascending, wrapping from NUM_CH-1 to 0.
    - Latch the winner index, address, wdata, byte enables and op into registers.
    - Go to BUSY.
  - If no channel requests, stay in IDLE.
- Op encoding: if ch_read and ch_write are both high on the winner, the write wins and the read is ignored.
- BUSY:
  - mem_read or mem_write is driven from the latched op. mem_address, mem_wdata and mem_byte_enable come from the latches.
  - Requester inputs are ignored while in BUSY. Changes to the granted channel's request mid-transaction have no effect.
- Completion, on mem_resp in BUSY:
  - ch_resp[grant] = 1 combinationally in the same cycle.
  - ch_rdata = mem_rdata (pass-through, always driven).
  - Next state is IDLE.
  - rr_ptr ← (grant == NUM_CH-1) ? 0 : grant+1.
- mem_resp in IDLE is ignored: ch_resp stays 0 and there is no state change.
- Pointer/index width is $clog2(NUM_CH). Indices ≥ NUM_CH are never produced.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, ch_resp=0, busy=0, rr_ptr=0.
  - ch_rdata follows mem_rdata and has no register.
- Request-to-downstream latency: a request sampled at edge N (IDLE) gives mem_read/mem_write high in the cycle after edge N.
- Response latency: zero cycles. ch_resp is asserted in the same cycle as mem_resp.
- There is one mandatory IDLE cycle after each completion. The requester drops its request on the edge where it sees ch_resp, so the arbiter never re-grants a stale request.
- Back-to-back service: with continuous requests, grant spacing is (downstream latency + 1) cycles.
- mem_* outputs are registered and stable for the entire BUSY period.
- Reset mid-BUSY: all outputs return to their reset values immediately (asynchronous) and the transaction is abandoned. The downstream port must be reset by the same rst.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest requesting index always wins. rr_ptr is not implemented and is treated as constant 0.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset: assert rst mid-cycle with ch_read=all ones -> all outputs 0 asynchronously; busy=0 until one cycle after rst deasserts.
- Single read: ch_read[1]=1, ch_address ch1=0x0000_0100 -> next cycle mem_read=1, mem_address=0x100. Drive mem_resp with mem_rdata=0xDEAD_BEEF after 3 cycles -> ch_resp=2'b10 in the same cycle, ch_rdata=0xDEAD_BEEF; then one IDLE cycle.
- Contention, NUM_CH=4: all four channels requesting continuously after reset -> grant order 0,1,2,3,0,1. Each channel gets exactly one ch_resp per round.
- Write passthrough: ch_write[2]=1, address 0x8000_0004, wdata 0x1234_5678, byte_enable 4'b0011 -> mem_write=1 with identical fields. Changing ch_wdata mid-BUSY does not change mem_wdata.
- Read+write on the same channel -> mem_write=1, mem_read=0. mem_resp in IDLE -> no ch_resp and no state change.
- With ARB_FIXED_PRIO_EN, NUM_CH=3, ch0 and ch2 both requesting continuously -> ch0 granted every time and ch2 never. Without the macro -> ch0 and ch2 alternate.
